// File: rtl/voice_mixer_if.sv
// Bundles the voice-sample input handshake, the audio FIFO write port and the
// mixer status outputs into a single interface.
interface voice_mixer_if #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 24
);
  logic [NUM_VOICES*SAMPLE_W-1:0] voice_data;
  logic [NUM_VOICES-1:0]          voice_active;
  logic                           voice_valid;
  logic                           voice_ready;
  logic [7:0]                     master_gain;
  logic                           fifo_full;
  logic [SAMPLE_W-1:0]            audio_out;
  logic                           fifo_write;
  logic                           clip;
  logic [7:0]                     drop_cnt;

  modport master (
    output voice_data, voice_active, voice_valid, master_gain, fifo_full,
    input  voice_ready, audio_out, fifo_write, clip, drop_cnt
  );

  modport slave (
    input  voice_data, voice_active, voice_valid, master_gain, fifo_full,
    output voice_ready, audio_out, fifo_write, clip, drop_cnt
  );
endinterface

// File: rtl/voice_mixer.sv
// Sequential voice mixer: snapshots a sample set, sums one voice per cycle,
// applies master gain with saturation and writes one word to the audio FIFO.
module voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 24
) (
  input  logic          clk,
  input  logic          reset_n,
  voice_mixer_if.slave  bus
);

  localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int PROD_W = ACC_W + 9;
  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic signed [PROD_W-1:0] SAT_MAX =
    {{(PROD_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, WRITE} state_t;

  state_t state, next_state;

  logic [NUM_VOICES*SAMPLE_W-1:0] snap_data;
  logic [NUM_VOICES-1:0]          snap_active;
  logic [IDX_W-1:0]               voice_idx;
  logic signed [ACC_W-1:0]        acc;
  logic [SAMPLE_W-1:0]            audio_q;
  logic                           clip_q;
  logic [7:0]                     drop_q;

  logic                           ready;
  logic                           write_en;
  logic                           accept;
  logic signed [SAMPLE_W-1:0]     cur_voice;
  logic signed [ACC_W-1:0]        addend;
  logic signed [8:0]              gain_s;
  logic signed [PROD_W-1:0]       product;
  logic signed [PROD_W-1:0]       scaled;
  logic [SAMPLE_W-1:0]            sat_value;
  logic                           sat_hit;

  // NOTE: state updates use non-blocking assignments so every register in the
  // block samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    write_en   = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.voice_valid) next_state = ACCUM;
      end
      ACCUM: begin
        if (voice_idx == LAST_IDX) next_state = SCALE;
      end
      SCALE: begin
        next_state = WRITE;
      end
      WRITE: begin
        write_en = ~bus.fifo_full;
        if (!bus.fifo_full) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && bus.voice_valid;

  always_comb begin
    cur_voice = snap_data[int'(voice_idx)*SAMPLE_W +: SAMPLE_W];
    addend    = snap_active[voice_idx] ? ACC_W'(cur_voice) : '0;
  end

  // Gain is read live in the SCALE cycle, so late gain changes still apply.
  always_comb begin
    gain_s    = signed'({1'b0, bus.master_gain});
    product   = PROD_W'(acc) * PROD_W'(gain_s);
    scaled    = product >>> 7;
    sat_hit   = 1'b0;
    sat_value = scaled[SAMPLE_W-1:0];
    if (scaled > SAT_MAX) begin
      sat_hit   = 1'b1;
      sat_value = SAT_MAX[SAMPLE_W-1:0];
    end else if (scaled < SAT_MIN) begin
      sat_hit   = 1'b1;
      sat_value = SAT_MIN[SAMPLE_W-1:0];
    end
  end

  // NOTE: the snapshot registers are plain storage with no reset; they are
  // always loaded on acceptance before anything reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      snap_data   <= bus.voice_data;
      snap_active <= bus.voice_active;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc       <= '0;
      voice_idx <= '0;
      audio_q   <= '0;
      clip_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc       <= '0;
            voice_idx <= '0;
          end
        end
        ACCUM: begin
          acc       <= acc + addend;
          voice_idx <= voice_idx + IDX_W'(1);
        end
        SCALE: begin
          audio_q <= sat_value;
          clip_q  <= sat_hit;
        end
        default: ;
      endcase
    end
  end

  // Every strobe outside IDLE is a drop, including one on the WRITE exit cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_q <= '0;
    end else if (bus.voice_valid && (state != IDLE) && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.voice_ready = ready;
  assign bus.fifo_write  = write_en;
  assign bus.audio_out   = audio_q;
  assign bus.clip        = clip_q;
  assign bus.drop_cnt    = drop_q;

endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001: Parameter NUM_VOICES, default 4, number of synth voices mixed per sample.
REQ-002: Parameter SAMPLE_W, default 24, signed sample width of each voice and of the mixed output.
REQ-003: CLK  input  1  system clock, the same domain as the audio FIFO write side.
REQ-004: RESET_N  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005: VOICE_DATA  input  NUM_VOICES*SAMPLE_W  packed signed voice samples, with voice k at bits [k*SAMPLE_W +: SAMPLE_W].
REQ-006: VOICE_ACTIVE  input  NUM_VOICES  per-voice enable; an inactive voice contributes 0.
REQ-007: VOICE_VALID  input  1  one-cycle strobe that a new sample set is present.
REQ-008: VOICE_READY  output  1  high only when the block can accept VOICE_VALID.
REQ-009: MASTER_GAIN  input  8  unsigned gain; 128 is unity.
REQ-010: FIFO_FULL  input  1  audio FIFO write-side full flag.
REQ-011: AUDIO_OUT  output  SAMPLE_W  mixed signed sample presented to the FIFO data port.
REQ-012: FIFO_WRITE  output  1  FIFO write request; a word is transferred on every cycle where it is high.
REQ-013: CLIP  output  1  high while the held AUDIO_OUT value was saturated.
REQ-014: DROP_CNT  output  8  count of rejected VOICE_VALID strobes, saturating at 255.

Function
REQ-015: The FSM SHALL use the states IDLE, ACCUM, SCALE and WRITE.
REQ-016: IDLE: VOICE_READY=1; VOICE_VALID=1 snapshots VOICE_DATA and VOICE_ACTIVE, clears the accumulator and moves to ACCUM.
REQ-017: ACCUM: one voice per cycle, ascending index, for exactly NUM_VOICES cycles, then SCALE.
REQ-018: The accumulator SHALL be signed, SAMPLE_W+clog2(NUM_VOICES) bits wide (26 at defaults), so it never overflows.
REQ-019: SCALE, single cycle: product = accumulator * {1'b0,MASTER_GAIN} (signed), arithmetic shift right 7 (truncate toward -inf).
REQ-020: Saturation: clamp to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]; register to AUDIO_OUT; CLIP=1 iff the clamp was applied; then WRITE.
REQ-021: MASTER_GAIN SHALL be sampled in the SCALE cycle, not at the snapshot.
REQ-022: WRITE: FIFO_WRITE = ~FIFO_FULL; on the first cycle with FIFO_FULL=0, the word is written and the next state is IDLE.
REQ-023: WRITE waits indefinitely while FIFO_FULL=1, with AUDIO_OUT and CLIP held stable.
REQ-024: FIFO_WRITE SHALL be 0 in every state except WRITE, giving at most one write per accepted sample set.
REQ-025: Latency: VOICE_VALID accepted at cycle 0 -> FIFO_WRITE at cycle NUM_VOICES+2 (cycle 6 at defaults) if not full; VOICE_READY again the following cycle.
REQ-026: VOICE_VALID while not in IDLE SHALL be ignored, with DROP_CNT incremented, saturating at 255, no wrap.
REQ-027: A VOICE_VALID in the same cycle that WRITE completes SHALL count as dropped, because READY is only high in IDLE.
REQ-028: Snapshotted voice data SHALL be unaffected by input changes after acceptance.
REQ-029: AAUDIO_OUT and CLIP SHALL retain the last written value while IDLE.

Reset
REQ-030: With RESET_N=0 at a clock edge: state=IDLE, accumulator=0, AUDIO_OUT=0, CLIP=0, DROP_CNT=0.
REQ-031: After that reset edge: FIFO_WRITE=0 and VOICE_READY=1.
REQ-032: Reset mid-operation (ACCUM, SCALE or WRITE) SHALL discard the sample in progress with no FIFO_WRITE issued.
REQ-033: VOICE_VALID is ignored while RESET_N=0 and SHALL NOT increment DROP_CNT.

Verification
REQ-034: Unity mix: four voices of 0x000100, all active, gain 128 -> AUDIO_OUT=0x000400, FIFO_WRITE exactly at cycle 6 for one cycle, CLIP=0.
REQ-035: Saturation, positive and negative:
- all voices 0x7FFFFF, gain 255 -> 0x7FFFFF, CLIP=1;
- all voices 0x800000, gain 255 -> 0x800000, CLIP=1.
REQ-036: Masking and sign: VOICE_ACTIVE=4'b0101, voices 0x10/0x20/0x30/0x40, gain 128 -> 0x000040; then only voice 0 = -0x200, gain 64 -> 0xFFFF00.
REQ-037: Back-pressure: FIFO_FULL=1 for 10 cycles on entering WRITE -> FIFO_WRITE=0 and AUDIO_OUT stable throughout, one write on the first non-full cycle; 3 VOICE_VALID strobes in that window -> DROP_CNT=3.
REQ-038: DROP_CNT saturation: 300 rejected strobes -> DROP_CNT=255.
REQ-039: Reset mid-ACCUM -> no FIFO_WRITE, all outputs at reset values; the next valid set mixes correctly.
